// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths and named half-period constants for the clock dividers
package clk_div_pkg;
    localparam int DEF_CNT_W  = 25;
    localparam int HP_1HZ_50M = 25_000_000;
    localparam int HP_SCAN_1K = 25_000;
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one programmable divider channel with shadowed half-period
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             tick
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_sh;

    // sync/disable reload the shadow; a zero shadow freezes; terminal count toggles and reloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_sh  <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (sync || !en) begin
            cnt     <= '0;
            div_sh  <= div;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (div_sh == '0) begin
            tick    <= 1'b0;
        end else if (cnt == div_sh - CNT_W'(1)) begin
            cnt     <= '0;
            div_sh  <= div;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            tick    <= 1'b0;
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent programmable clock dividers sharing one sync input
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic                  sync,
    input  logic [N_CH*CNT_W-1:0] div,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .sync    (sync),
            .div     (div[i*CNT_W +: CNT_W]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scenario and random checks of clk_div_multi against a countdown model
module tb_clk_div_multi;
    localparam int N_CH  = 2;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  sync = 1'b0;
    logic [N_CH-1:0]       en = '0;
    logic [N_CH*CNT_W-1:0] div = '0;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;

    logic [N_CH-1:0] m_out;
    logic [N_CH-1:0] m_tick;
    int              m_left [N_CH];
    int              tests = 0;
    int              fails = 0;

    clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .div     (div),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // free-running board clock
    always #5 clk = ~clk;

    task automatic set_div(input int c, input int v);
        div[c*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_tick = '0;
        for (int c = 0; c < N_CH; c++) m_left[c] = 0;
    endtask

    // m_left = edges remaining before the next toggle; 0 means the channel is frozen
    task automatic model_step();
        int d;
        for (int c = 0; c < N_CH; c++) begin
            d = int'(div[c*CNT_W +: CNT_W]);
            if (sync || !en[c]) begin
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
                m_left[c] = d;
            end else if (m_left[c] == 0) begin
                m_tick[c] = 1'b0;
            end else begin
                m_left[c]--;
                m_tick[c] = (m_left[c] == 0);
                if (m_left[c] == 0) begin
                    m_out[c]  = ~m_out[c];
                    m_left[c] = d;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #12;
        model_reset();
        tests++;
        if ({clk_out, tick} !== '0) begin
            fails++;
            $display("FAIL reset_state: got out=%b tick=%b want 0", clk_out, tick);
        end
        rst_n = 1'b1;
        set_div(0, 5);
        step();
        en[0] = 1'b1;
        repeat (8) begin
            step();
            tests++;
            if (clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL reset_precount: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, m_out, m_tick);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got out=%b tick=%b want 0 0", clk_out[0], tick[0]);
        end
        #3 rst_n = 1'b1;
        en[0] = 1'b0;
        step();
        en[0] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[0] && n < 50);
        tests++;
        if (n != 5 || clk_out[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_toggle: got edge=%0d out=%b want edge=5 out=1", n, clk_out[0]);
        end
    endtask

    task automatic test_div5();
        int ticks, highs;
        en = '0;
        set_div(0, 5);
        step();
        en[0] = 1'b1;
        ticks = 0;
        highs = 0;
        repeat (40) begin
            step();
            ticks += int'(tick[0]);
            highs += int'(clk_out[0]);
            tests++;
            if (clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL div5_wave: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, m_out, m_tick);
            end
        end
        tests++;
        if (ticks != 8 || highs != 20) begin
            fails++;
            $display("FAIL div5_counts: got ticks=%0d highs=%0d want 8 20", ticks, highs);
        end
    endtask

    task automatic test_div1_div0();
        logic prev;
        en = '0;
        set_div(0, 1);
        step();
        en[0] = 1'b1;
        prev = clk_out[0];
        repeat (8) begin
            step();
            tests++;
            if (tick[0] !== 1'b1 || clk_out[0] !== ~prev || clk_out !== m_out) begin
                fails++;
                $display("FAIL div1_half: got out=%b tick=%b want out=%b tick=1", clk_out[0], tick[0], ~prev);
            end
            prev = clk_out[0];
        end
        set_div(0, 0);
        en[0] = 1'b0;
        step();
        en[0] = 1'b1;
        repeat (10) begin
            step();
            tests++;
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL div0_frozen: got out=%b tick=%b want out=0 tick=0", clk_out[0], tick[0]);
            end
        end
    endtask

    task automatic test_midchange();
        int t1, t2, t3, n;
        en = '0;
        set_div(0, 6);
        step();
        en[0] = 1'b1;
        step();
        set_div(0, 2);
        n = 1;
        t1 = 0;
        t2 = 0;
        t3 = 0;
        while (n < 30 && t3 == 0) begin
            step();
            n++;
            if (tick[0]) begin
                if (t1 == 0) t1 = n;
                else if (t2 == 0) t2 = n;
                else t3 = n;
            end
            tests++;
            if (clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL midchange_wave: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, m_out, m_tick);
            end
        end
        tests++;
        if (t1 != 6 || t2 != 8 || t3 != 10) begin
            fails++;
            $display("FAIL midchange_edges: got %0d %0d %0d want 6 8 10", t1, t2, t3);
        end
    endtask

    task automatic test_sync();
        int t0, t1, n;
        en = '0;
        set_div(0, 4);
        set_div(1, 8);
        step();
        en[0] = 1'b1;
        repeat (3) step();
        en[1] = 1'b1;
        repeat (10) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        tests++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            fails++;
            $display("FAIL sync_clear: got out=%b tick=%b want 00 00", clk_out, tick);
        end
        t0 = 0;
        t1 = 0;
        n = 0;
        while (n < 20 && t1 == 0) begin
            step();
            n++;
            if (tick[0] && t0 == 0) t0 = n;
            if (tick[1] && t1 == 0) t1 = n;
            tests++;
            if (clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL sync_wave: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, m_out, m_tick);
            end
        end
        tests++;
        if (t0 != 4 || t1 != 8) begin
            fails++;
            $display("FAIL sync_align: got ch0=%0d ch1=%0d want 4 8", t0, t1);
        end
    endtask

    task automatic test_disable();
        int n;
        n = 0;
        while (clk_out[1] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        tests++;
        if (clk_out[1] !== 1'b1) begin
            fails++;
            $display("FAIL disable_wait: got out1=%b want 1 within 40 edges", clk_out[1]);
        end
        en[1] = 1'b0;
        step();
        tests++;
        if (clk_out[1] !== 1'b0 || clk_out[0] !== m_out[0] || tick[0] !== m_tick[0]) begin
            fails++;
            $display("FAIL disable_drop: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, {1'b0, m_out[0]}, m_tick);
        end
        en[1] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            tests++;
            if (clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL disable_wave: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, m_out, m_tick);
            end
        end while (!tick[1] && n < 40);
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL reenable_toggle: got edge=%0d want 8", n);
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 9) == 0) set_div(c, int'($urandom_range(0, 6)));
            end
            sync = ($urandom_range(0, 39) == 0);
            step();
            tests++;
            if (clk_out !== m_out || tick !== m_tick) begin
                fails++;
                $display("FAIL random: got out=%b tick=%b want out=%b tick=%b", clk_out, tick, m_out, m_tick);
            end
        end
        sync = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div5();
        test_div1_div0();
        test_midchange();
        test_sync();
        test_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
